// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable clock dividers sharing one clock.
// Each channel counts 0..L, then wraps. On the wrap it emits a one-cycle tick
// and flips a toggle flop. hzX selects tick or toggle per channel via mode.
// A global sync restarts every channel in phase.
// Optional feature macro: CLKDIV_SHADOW_EN. When defined, each channel latches
// its limit into a shadow register at reset, at sync and at every wrap. When
// undefined, the compare uses the live lim input.
module clkdiv_multi #(
    parameter int unsigned BITLEN = 8,
    parameter int unsigned NCH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        en,
    input  logic [NCH-1:0]        mode,
    input  logic                  sync,
    input  logic [NCH*BITLEN-1:0] lim,
    output logic [NCH-1:0]        tick,
    output logic [NCH-1:0]        hzX
);

    logic [BITLEN-1:0] cnt_q   [NCH];
    logic [BITLEN-1:0] cnt_d   [NCH];
    logic [BITLEN-1:0] lim_in  [NCH];
    logic [BITLEN-1:0] lim_cur [NCH];
    logic [NCH-1:0]    tog_q;
    logic [NCH-1:0]    tog_d;
    logic [NCH-1:0]    tick_q;
    logic [NCH-1:0]    tick_d;
    logic [NCH-1:0]    wrap_c;

    // Unpack the flattened limit bus into one word per channel
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            lim_in[i] = lim[i*BITLEN +: BITLEN];
        end
    end

`ifdef CLKDIV_SHADOW_EN
    logic [BITLEN-1:0] lim_q [NCH];
    logic [BITLEN-1:0] lim_d [NCH];

    // Compare against the limit captured at the start of the current period
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            lim_cur[i] = lim_q[i];
        end
    end

    // Shadow limit reloads at sync and at each wrap so lim changes never truncate a period
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            lim_d[i] = lim_q[i];
            if (sync || wrap_c[i]) begin
                lim_d[i] = lim_in[i];
            end
        end
    end

    // Shadow limit register
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (!rst) begin
                lim_q[i] <= lim_in[i];
            end else begin
                lim_q[i] <= lim_d[i];
            end
        end
    end
`else
    // Compare directly against the live limit input
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            lim_cur[i] = lim_in[i];
        end
    end
`endif

    // Wrap detect: an enabled channel whose count has reached its limit
    always_comb begin
        wrap_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            wrap_c[i] = en[i] && (cnt_q[i] == lim_cur[i]);
        end
    end

    // Next-state for counters, toggles and ticks; sync overrides enable
    always_comb begin
        tog_d  = tog_q;
        tick_d = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync) begin
                cnt_d[i] = '0;
                tog_d[i] = 1'b0;
            end else if (wrap_c[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                tog_d[i]  = ~tog_q[i];
            end else if (en[i]) begin
                // Plain modulo-2^BITLEN increment; a lowered live limit rolls over
                cnt_d[i] = cnt_q[i] + BITLEN'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            tog_q  <= '0;
            tick_q <= '0;
        end else begin
            tog_q  <= tog_d;
            tick_q <= tick_d;
        end
        for (int i = 0; i < int'(NCH); i++) begin
            if (!rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Outputs: tick is registered; hzX muxes two registered flops by mode
    assign tick = tick_q;
    assign hzX  = (mode & tick_q) | (~mode & tog_q);

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi (BITLEN=8, NCH=4).
// A behavioural reference predicts tick/hzX for each edge; predictions are
// queued when inputs are applied and popped after the edge for comparison.
// Honours CLKDIV_SHADOW_EN the same way the design does.
module tb_clkdiv_multi;

    localparam int unsigned BITLEN = 8;
    localparam int unsigned NCH    = 4;
    localparam int          MODV   = 2 ** BITLEN;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        en;
    logic [NCH-1:0]        mode;
    logic                  sync;
    logic [NCH*BITLEN-1:0] lim;
    logic [NCH-1:0]        tick;
    logic [NCH-1:0]        hzX;

    int checks = 0;
    int errors = 0;

    // reference state: phase count, period limit, toggle and tick per channel
    int m_cnt  [NCH];
    int m_lim  [NCH];
    bit m_tog  [NCH];
    bit m_tick [NCH];

    logic [NCH-1:0] exp_tick_q[$];
    logic [NCH-1:0] exp_hz_q[$];

    clkdiv_multi #(.BITLEN(BITLEN), .NCH(NCH)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .sync (sync),
        .lim  (lim),
        .tick (tick),
        .hzX  (hzX)
    );

    always #5 clk = ~clk;

    function automatic int lim_of(input int ch);
        logic [BITLEN-1:0] w;
        w = lim[ch*BITLEN +: BITLEN];
        return int'(w);
    endfunction

    task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict the effect of the coming edge given the inputs now applied
    task automatic model_edge();
        logic [NCH-1:0] et;
        logic [NCH-1:0] eh;
        for (int i = 0; i < int'(NCH); i++) begin
            int lcmp;
`ifdef CLKDIV_SHADOW_EN
            lcmp = m_lim[i];
`else
            lcmp = lim_of(i);
`endif
            if (!rst || sync) begin
                m_cnt[i]  = 0;
                m_tog[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_lim[i]  = lim_of(i);
            end else if (en[i]) begin
                if (m_cnt[i] == lcmp) begin
                    m_cnt[i]  = 0;
                    m_tick[i] = 1'b1;
                    m_tog[i]  = !m_tog[i];
                    m_lim[i]  = lim_of(i);
                end else begin
                    m_cnt[i]  = (m_cnt[i] + 1) % MODV;
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
            et[i] = m_tick[i];
            eh[i] = mode[i] ? m_tick[i] : m_tog[i];
        end
        exp_tick_q.push_back(et);
        exp_hz_q.push_back(eh);
    endtask

    // One clock: queue prediction, advance, then compare just after the edge
    task automatic step(input string tag);
        logic [NCH-1:0] et;
        logic [NCH-1:0] eh;
        model_edge();
        @(posedge clk);
        #1;
        et = exp_tick_q.pop_front();
        eh = exp_hz_q.pop_front();
        check({tag, "/tick"}, tick, et);
        check({tag, "/hzX"}, hzX, eh);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        int a;
        int b;
        int gap;
        rst  = 1'b0;
        en   = '0;
        mode = '0;
        sync = 1'b0;
        lim  = {8'd3, 8'd2, 8'd1, 8'd0};

        // reset held for a few edges: outputs must be 0
        run("reset", 3);
        check("reset_tick_zero", tick, 4'b0000);
        check("reset_hz_zero", hzX, 4'b0000);

        // basic square-wave division, lims 3,2,1,0
        rst = 1'b1;
        en  = 4'b1111;
        run("square", 24);

        // ch0 pulse mode, lim 4; sync first to start cleanly
        lim[7:0] = 8'd4;
        mode[0]  = 1'b1;
        sync     = 1'b1;
        step("pulse_sync");
        sync     = 1'b0;
        run("pulse", 16);

        // ch0 lim 9 with an enable gap of 7 cycles after edge 4
        lim[7:0] = 8'd9;
        sync     = 1'b1;
        step("gap_sync");
        sync     = 1'b0;
        run("gap_pre", 4);
        en[0] = 1'b0;
        run("gap_off", 7);
        check_int("gap_hold_q", int'(dut.cnt_q[0]), 4);
        en[0] = 1'b1;
        gap = 0;
        while (gap < 20 && tick[0] !== 1'b1) begin
            step("gap_on");
            gap++;
        end
        check_int("gap_resume_edges", gap, 6);
        run("gap_post", 12);

        // random lims with one sync pulse mid-run; ch0/ch1 share a limit
        mode = '0;
        a = $urandom_range(1, 6);
        b = $urandom_range(0, 7);
        lim = {8'(b), 8'($urandom_range(0, 7)), 8'(a), 8'(a)};
        run("rand_pre", 13);
        sync = 1'b1;
        step("rand_sync");
        sync = 1'b0;
        check("rand_sync_hz_zero", hzX, 4'b0000);
        run("rand_post", 20);

        // sync landing exactly on a wrap edge suppresses the tick
        lim  = {8'd3, 8'd3, 8'd3, 8'd3};
        sync = 1'b1;
        step("wrap_sync0");
        sync = 1'b0;
        run("wrap_cnt", 3);
        sync = 1'b1;
        step("wrap_sync1");
        check("wrap_sync_no_tick", tick, 4'b0000);
        check("wrap_sync_tog_zero", hzX, 4'b0000);
        sync = 1'b0;
        run("wrap_after", 8);

        // ch0 lim 7 lowered to 2 while Q=5
        lim[7:0] = 8'd7;
        mode[0]  = 1'b1;
        sync     = 1'b1;
        step("shadow_sync");
        sync = 1'b0;
        run("shadow_pre", 5);
        lim[7:0] = 8'd2;
        gap = 0;
        do begin
            step("shadow_run");
            gap++;
        end while (gap < 300 && tick[0] !== 1'b1);
`ifdef CLKDIV_SHADOW_EN
        check_int("shadow_first_wrap", gap, 3);
`else
        check_int("live_first_wrap", gap, 254);
`endif
        run("shadow_post", 9);

        // reset mid-count while ch3 toggle output is high
        mode = '0;
        lim  = {8'd3, 8'd2, 8'd1, 8'd0};
        sync = 1'b1;
        step("rst_sync");
        sync = 1'b0;
        run("rst_pre", 5);
        check("rst_pre_ch3_high", {3'b000, hzX[3]}, 4'b0001);
        rst = 1'b0;
        lim = {8'd1, 8'd3, 8'd2, 8'd4};
        step("rst_pulse");
        check("rst_hz_zero", hzX, 4'b0000);
        check("rst_tick_zero", tick, 4'b0000);
        rst = 1'b1;
        run("rst_post", 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
